// File: rtl/gpio_serial_cfg_loader.sv
`default_nettype none
// =============================================================================
// gpio_serial_cfg_loader - streams one config word per pad, MSB first, into the
// daisy-chained pad control blocks and then strobes the load.  Rev 1.0
// =============================================================================
module gpio_serial_cfg_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 1,
    parameter int AW       = $clog2(NUM_PADS)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load,
    output logic                cfg_applied
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam logic [PW-1:0] c_ph_last  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] c_bit_top  = BW'(CFG_BITS - 1);
    localparam logic [AW-1:0] c_addr_top = AW'(NUM_PADS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_fetch2;
    logic [PW-1:0]       r_phase;
    logic [BW-1:0]       r_bit;
    logic [CFG_BITS-1:0] r_shreg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state         <= ST_IDLE;
            r_fetch2        <= 1'b0;
            r_phase         <= '0;
            r_bit           <= '0;
            r_shreg         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_addr        <= '0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
            cfg_applied     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_addr    <= c_addr_top;
                        cfg_applied <= 1'b0;
                        busy        <= 1'b1;
                        r_fetch2    <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                // Two cycles so a registered read port has settled before capture
                ST_FETCH: begin
                    if (!r_fetch2) begin
                        r_fetch2 <= 1'b1;
                    end else begin
                        r_shreg         <= cfg_data;
                        r_bit           <= c_bit_top;
                        r_phase         <= '0;
                        serial_clock    <= 1'b0;
                        serial_data_out <= cfg_data[CFG_BITS-1];
                        r_state         <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_phase != c_ph_last) begin
                        r_phase <= r_phase + 1'b1;
                    end else begin
                        r_phase <= '0;
                        if (!serial_clock) begin
                            serial_clock <= 1'b1;
                        end else begin
                            r_shreg      <= r_shreg << 1;
                            serial_clock <= 1'b0;
                            if (r_bit != '0) begin
                                r_bit           <= r_bit - 1'b1;
                                serial_data_out <= r_shreg[CFG_BITS-2];
                            end else if (cfg_addr != '0) begin
                                cfg_addr <= cfg_addr - 1'b1;
                                r_fetch2 <= 1'b0;
                                r_state  <= ST_FETCH;
                            end else begin
                                serial_data_out <= 1'b0;
                                serial_load     <= 1'b1;
                                r_state         <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (r_phase != c_ph_last) begin
                        r_phase <= r_phase + 1'b1;
                    end else begin
                        r_phase     <= '0;
                        serial_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cfg_applied <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_serial_cfg_loader.sv
`default_nettype none
// =============================================================================
// tb_gpio_serial_cfg_loader - directed checks on three parameterisations with a
// behavioural pad chain latched on serial_load.  Rev 1.0
// =============================================================================
module tb_gpio_serial_cfg_loader;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, start_c;
    always #5 clk = ~clk;

    // a: 2 pads x 4 bits, CLK_DIV=1 ; b: same with CLK_DIV=3 ; c: defaults
    logic busy_a, done_a, sc_a, sdo_a, load_a, app_a;
    logic busy_b, done_b, sc_b, sdo_b, load_b, app_b;
    logic busy_c, done_c, sc_c, sdo_c, load_c, app_c;
    logic [0:0] addr_a, addr_b;
    logic [5:0] addr_c;
    logic [3:0] data_a, data_b;
    logic [12:0] data_c;
    logic [12:0] mem_c [38];
    logic [12:0] old_c [38];

    assign data_a = addr_a ? 4'hA : 4'h5;
    assign data_b = addr_b ? 4'hA : 4'h5;
    always @(posedge clk) data_c <= mem_c[addr_c];

    gpio_serial_cfg_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .cfg_addr(addr_a), .cfg_data(data_a), .serial_clock(sc_a),
        .serial_data_out(sdo_a), .serial_load(load_a), .cfg_applied(app_a));

    gpio_serial_cfg_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(3)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .cfg_addr(addr_b), .cfg_data(data_b), .serial_clock(sc_b),
        .serial_data_out(sdo_b), .serial_load(load_b), .cfg_applied(app_b));

    gpio_serial_cfg_loader dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .cfg_addr(addr_c), .cfg_data(data_c), .serial_clock(sc_c),
        .serial_data_out(sdo_c), .serial_load(load_c), .cfg_applied(app_c));

    // Behavioural pad chains: bits enter at index 0, pad k ends at [k*B +: B]
    logic [7:0]   chain_a, latch_a, chain_b, latch_b;
    logic [493:0] chain_c, latch_c;
    int nbits_a = 0;
    always @(posedge sc_a) begin chain_a <= {chain_a[6:0], sdo_a}; nbits_a <= nbits_a + 1; end
    always @(posedge load_a) latch_a <= chain_a;
    always @(posedge sc_b) chain_b <= {chain_b[6:0], sdo_b};
    always @(posedge load_b) latch_b <= chain_b;
    always @(posedge sc_c) chain_c <= {chain_c[492:0], sdo_c};
    always @(posedge load_c) latch_c <= chain_c;

    int ecnt = 0;
    int t0 = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int done_n_a, done_at_a, load_n_a, load_at_a, rise1_a;
    int done_n_b, done_at_b, load_n_b, rise1_b, rise2_b;
    int done_n_c, done_at_c, load_n_c, viol_c;
    logic prev_sc_a, prev_sc_b, prev_sdo_c;

    // Sampled mid-cycle; rel 1 is the cycle right after the start edge
    always @(negedge clk) begin
        if (done_a) begin done_n_a++; done_at_a = ecnt - t0 + 1; end
        if (load_a) begin load_n_a++; load_at_a = ecnt - t0 + 1; end
        if (sc_a === 1'b1 && prev_sc_a === 1'b0 && rise1_a == 0) rise1_a = ecnt - t0 + 1;
        prev_sc_a = sc_a;
        if (done_b) begin done_n_b++; done_at_b = ecnt - t0 + 1; end
        if (load_b) load_n_b++;
        if (sc_b === 1'b1 && prev_sc_b === 1'b0) begin
            if (rise1_b == 0) rise1_b = ecnt - t0 + 1;
            else if (rise2_b == 0) rise2_b = ecnt - t0 + 1;
        end
        prev_sc_b = sc_b;
        if (done_c) begin done_n_c++; done_at_c = ecnt - t0 + 1; end
        if (load_c) load_n_c++;
        if (sc_c === 1'b1 && sdo_c !== prev_sdo_c) viol_c++;
        prev_sdo_c = sdo_c;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        for (int k = 0; k < 38; k++) mem_c[k] = 13'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        @(negedge clk);
        check("reset_a", {busy_a, done_a, sc_a, sdo_a, load_a, app_a, addr_a}, 64'd0);
        check("reset_b", {busy_b, done_b, sc_b, sdo_b, load_b, app_b, addr_b}, 64'd0);
        check("reset_c", {busy_c, done_c, sc_c, sdo_c, load_c, app_c, addr_c}, 64'd0);
        @(negedge clk);
        check("start_in_reset_ignored", {busy_a, busy_b, busy_c}, 64'd0);

        done_n_a = 0; load_n_a = 0; rise1_a = 0; done_at_a = 0; load_at_a = 0;
        done_n_b = 0; load_n_b = 0; rise1_b = 0; rise2_b = 0; done_at_b = 0;
        done_n_c = 0; load_n_c = 0; viol_c = 0; done_at_c = 0;

        // All three launched on the same edge
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        @(posedge clk); #1;
        t0 = ecnt;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        @(negedge clk);
        check("busy_after_start", {busy_a, busy_b, busy_c}, 64'h7);

        // Extra start pulse on a in the middle of pad 1's SHIFT
        while (ecnt - t0 + 1 < 8) @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;

        for (int i = 0; i < 1200 && done_n_c == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);

        check("a_stream", chain_a, 64'hA5);
        check("a_nbits", nbits_a, 64'd8);
        check("a_first_rise", rise1_a, 64'd4);
        check("a_load_at", load_at_a, 64'd21);
        check("a_load_cycles", load_n_a, 64'd1);
        check("a_done_at", done_at_a, 64'd22);
        check("a_done_pulses", done_n_a, 64'd1);
        check("a_latched", latch_a, 64'hA5);
        check("a_applied_idle", {app_a, busy_a}, 64'h2);

        check("b_first_rise", rise1_b, 64'd6);
        check("b_second_rise", rise2_b, 64'd12);
        check("b_load_cycles", load_n_b, 64'd3);
        check("b_done_at", done_at_b, 64'd56);
        check("b_latched", latch_b, 64'hA5);

        check("c_done_pulses", done_n_c, 64'd1);
        check("c_done_at", done_at_c, 64'd1066);
        check("c_sdo_stable_high", viol_c, 64'd0);
        check("c_applied", app_c, 64'd1);
        for (int k = 0; k < 38; k++) begin
            check($sformatf("c_pad%0d", k), latch_c[k*13 +: 13], mem_c[k]);
            old_c[k] = mem_c[k];
            mem_c[k] = ~mem_c[k];
        end

        // Reset during pad 0's SHIFT (rel 1039..1064) must leave the pads alone
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk); #1;
        t0 = ecnt;
        start_c = 1'b0;
        for (int i = 0; i < 1200 && (ecnt - t0 + 1) < 1050; i++) @(negedge clk);
        check("c_busy_before_reset", busy_c, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("c_mid_reset_idle", {busy_c, app_c, sc_c, sdo_c, load_c}, 64'd0);
        repeat (40) @(negedge clk);
        check("c_no_load_after_reset", load_n_c, 64'd1);
        check("c_no_done_after_reset", done_n_c, 64'd1);
        check("c_applied_after_reset", app_c, 64'd0);
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 38; k++)
                if (latch_c[k*13 +: 13] !== old_c[k]) bad++;
            check("c_pads_kept", bad, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
